word_loader: RTL and testbench

Front-end stage ahead of the vocabulary `matcher`. It accepts one word as a valid/ready byte stream and writes it null-terminated into the input SRAM. It then holds the matcher's chip select until the matcher reports `done`, and returns the `found` flag and matching vocab address through a result handshake. One word is in flight at a time.

---
 rtl/word_loader_if.sv | 57 +++++
 rtl/word_loader.sv | 140 ++++++++++++++
 tb/tb_word_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_loader_if.sv
// word_loader_if: byte stream in, input SRAM write port,
// matcher control/status and result handshake of word_loader.
// Ports (signals):
//   in_valid/in_ready/in_data/in_last   character stream
//   mem_cs/mem_we/mem_addr/mem_din      input SRAM write
//   match_cs/match_done/match_found/match_addr_v  matcher
//   res_valid/res_ready/res_found/res_addr/
//   res_overflow/res_timeout            result handshake
// Modports: master = environment, slave = word_loader.
interface word_loader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;

   logic                  mem_cs;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;

   logic                  match_cs;
   logic                  match_done;
   logic                  match_found;
   logic [ADDR_WIDTH-1:0] match_addr_v;

   logic                  res_valid;
   logic                  res_ready;
   logic                  res_found;
   logic [ADDR_WIDTH-1:0] res_addr;
   logic                  res_overflow;
   logic                  res_timeout;

   modport master (
      output in_valid, in_data, in_last,
      output match_done, match_found, match_addr_v,
      output res_ready,
      input  in_ready,
      input  mem_cs, mem_we, mem_addr, mem_din,
      input  match_cs,
      input  res_valid, res_found, res_addr,
      input  res_overflow, res_timeout
   );

   modport slave (
      input  in_valid, in_data, in_last,
      input  match_done, match_found, match_addr_v,
      input  res_ready,
      output in_ready,
      output mem_cs, mem_we, mem_addr, mem_din,
      output match_cs,
      output res_valid, res_found, res_addr,
      output res_overflow, res_timeout
   );
endinterface

// File: rtl/word_loader.sv
// word_loader: loads one null-terminated word into the input
// SRAM, runs the matcher on it and returns found/addr.
// Ports: clk, rst_n (async, active-low), bus (word_loader_if.slave)
//   stream in, SRAM write, matcher cs/status, result out.
module word_loader #(
   parameter int                    ADDR_WIDTH    = 4,
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [ADDR_WIDTH-1:0] INPUT_BASE    = '0,
   parameter int                    MATCH_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   word_loader_if.slave bus
);

   typedef enum logic [1:0] {
      LOAD,
      TERM,
      MATCH,
      RESULT
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LEN_MAX = '1;
   localparam logic [15:0] TMO = 16'(MATCH_TIMEOUT);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  found_q, found_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  ovf_q, ovf_d;
   logic                  tmo_q, tmo_d;

   logic nz;
   logic full;

   assign nz   = (bus.in_data != '0);
   assign full = (len_q == LEN_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         len_q   <= '0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         found_q <= found_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      found_d      = found_q;
      addr_d       = addr_q;
      ovf_d        = ovf_q;
      tmo_d        = tmo_q;
      bus.in_ready = 1'b0;
      bus.mem_cs   = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = INPUT_BASE + len_q;
      bus.mem_din  = {DATA_WIDTH{1'b0}};
      bus.match_cs = 1'b0;
      bus.res_valid = 1'b0;

      unique case (state_q)
         LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               // zero bytes would end the word early in SRAM
               if (nz && !full) begin
                  bus.mem_cs  = 1'b1;
                  bus.mem_we  = 1'b1;
                  bus.mem_din = bus.in_data;
                  len_d       = len_q + 1'b1;
               end else if (nz) begin
                  ovf_d = 1'b1;
               end
               if (bus.in_last) state_d = TERM;
            end
         end
         TERM: begin
            bus.mem_cs = 1'b1;
            bus.mem_we = 1'b1;
            cnt_d      = '0;
            if (len_q == '0) begin
               found_d = 1'b0;
               addr_d  = '0;
               state_d = RESULT;
            end else begin
               state_d = MATCH;
            end
         end
         MATCH: begin
            bus.match_cs = 1'b1;
            cnt_d        = cnt_q + 16'd1;
            if (bus.match_done) begin
               found_d = bus.match_found;
               addr_d  = bus.match_found ?
                         bus.match_addr_v : '0;
               state_d = RESULT;
            end else if (cnt_q + 16'd1 == TMO) begin
               found_d = 1'b0;
               addr_d  = '0;
               tmo_d   = 1'b1;
               state_d = RESULT;
            end
         end
         RESULT: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) begin
               len_d   = '0;
               cnt_d   = '0;
               found_d = 1'b0;
               addr_d  = '0;
               ovf_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign bus.res_found    = found_q;
   assign bus.res_addr     = addr_q;
   assign bus.res_overflow = ovf_q;
   assign bus.res_timeout  = tmo_q;

endmodule

// File: tb/tb_word_loader.sv
// tb_word_loader: random words against a word-level model,
// scoreboard queue of expected results, matcher model.
module tb_word_loader;
   localparam int AW  = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;
   localparam int CAP = (1 << AW) - 1;
   localparam logic [AW-1:0] BASE = 4'd0;

   localparam int M_FOUND = 0;
   localparam int M_MISS  = 1;
   localparam int M_HANG  = 2;

   typedef struct packed {
      logic          found;
      logic [AW-1:0] addr;
      logic          ovf;
      logic          tmo;
      logic          empty;
      logic [7:0]    beats;
   } exp_t;

   logic clk;
   logic rst_n;

   word_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   word_loader #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .INPUT_BASE   (BASE),
      .MATCH_TIMEOUT(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   exp_t       expq[$];
   logic [7:0] cur_chars[$];
   int         cur_mode  = M_MISS;
   int         cur_addr  = 0;
   int         cur_delay = 1;
   int         stall     = 0;
   int         cyc       = 0;

   logic [DW-1:0] sram [0:15];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_cs && bus.mem_we)
         sram[bus.mem_addr] <= bus.mem_din;
   end

   // consumer side of the result handshake
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (stall > 0) begin
            bus.res_ready = 1'b0;
            stall--;
         end else begin
            bus.res_ready = ($urandom % 4) != 0;
         end
      end
   end

   // matcher model; pulses spurious done while not selected
   initial begin
      int  mc;
      bit  busy;
      busy = 0;
      mc   = 0;
      bus.match_done   = 1'b0;
      bus.match_found  = 1'b0;
      bus.match_addr_v = '0;
      forever begin
         @(negedge clk);
         if (!rst_n || !bus.match_cs) begin
            busy = 0;
            bus.match_done   = ($urandom % 4) == 0;
            bus.match_found  = 1'b1;
            bus.match_addr_v = AW'($urandom);
         end else begin
            if (!busy) begin
               busy = 1;
               mc   = 0;
            end
            mc++;
            bus.match_done   = 1'b0;
            bus.match_found  = 1'($urandom);
            bus.match_addr_v = AW'($urandom);
            if (cur_mode != M_HANG && mc == cur_delay) begin
               bus.match_done  = 1'b1;
               bus.match_found = (cur_mode == M_FOUND);
               if (cur_mode == M_FOUND)
                  bus.match_addr_v = AW'(cur_addr);
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      int   acc, wr_idx;
      int   last_cyc, mstart, done_cyc, hs_cyc;
      bit   hs_ok, in_match, prev_rv;
      exp_t e;
      logic [AW+2:0] held, now_f;
      acc = 0; wr_idx = 0; last_cyc = 0; mstart = 0;
      done_cyc = 0; hs_cyc = 0; hs_ok = 0;
      in_match = 0; prev_rv = 0; held = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            check("rst_in_ready", bus.in_ready, 1);
            check("rst_mem_cs", bus.mem_cs, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_match_cs", bus.match_cs, 0);
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_res_fields",
                  {bus.res_found, bus.res_addr,
                   bus.res_overflow, bus.res_timeout}, 0);
            acc = 0; wr_idx = 0; hs_ok = 0;
            in_match = 0; prev_rv = 0;
            continue;
         end
         if (bus.in_valid && bus.in_ready) begin
            if (acc == 0 && hs_ok)
               check("b2b_first_beat", cyc, hs_cyc + 1);
            hs_ok = 0;
            acc++;
            if (bus.in_last) last_cyc = cyc;
         end
         if (bus.mem_cs && bus.mem_we) begin
            if (bus.mem_din != 0) begin
               check("wr_in_range",
                     wr_idx < cur_chars.size(), 1);
               if (wr_idx < cur_chars.size()) begin
                  check("wr_data", bus.mem_din,
                        cur_chars[wr_idx]);
                  check("wr_addr", bus.mem_addr,
                        AW'(BASE + wr_idx));
               end
               wr_idx++;
            end else begin
               check("term_addr", bus.mem_addr,
                     AW'(BASE + cur_chars.size()));
               check("term_cycle", cyc, last_cyc + 1);
               wr_idx = 0;
            end
         end
         if (bus.match_cs) begin
            check("match_mem_idle", bus.mem_cs, 0);
            check("match_in_ready", bus.in_ready, 0);
            if (!in_match) begin
               in_match = 1;
               mstart   = cyc;
               check("match_start", cyc, last_cyc + 2);
               check("match_nonempty",
                     cur_chars.size() != 0, 1);
               for (int i = 0; i <= cur_chars.size(); i++)
                  check("sram_word",
                        sram[AW'(BASE + i)],
                        (i < cur_chars.size()) ?
                        cur_chars[i] : 8'h00);
            end
            if (bus.match_done) done_cyc = cyc;
         end else begin
            in_match = 0;
         end
         if (bus.res_valid) begin
            check("res_in_ready", bus.in_ready, 0);
            check("res_match_cs", bus.match_cs, 0);
            now_f = {bus.res_found, bus.res_addr,
                     bus.res_overflow, bus.res_timeout};
            if (!prev_rv) begin
               check("res_expected", expq.size() != 0, 1);
               if (expq.size() != 0) begin
                  e = expq[0];
                  check("res_found", bus.res_found, e.found);
                  check("res_addr", bus.res_addr, e.addr);
                  check("res_overflow", bus.res_overflow,
                        e.ovf);
                  check("res_timeout", bus.res_timeout, e.tmo);
                  check("beats_accepted", acc, e.beats);
                  if (e.empty)
                     check("empty_latency", cyc, last_cyc + 2);
                  else if (e.tmo)
                     check("tmo_latency", cyc, mstart + TMO);
                  else
                     check("done_latency", cyc, done_cyc + 1);
               end
               held = now_f;
            end else begin
               check("res_stable", now_f, held);
            end
            if (bus.res_ready) begin
               if (expq.size() != 0) void'(expq.pop_front());
               hs_cyc = cyc;
               hs_ok  = bus.in_valid;
               acc    = 0;
            end
         end
         prev_rv = bus.res_valid && !bus.res_ready;
      end
   end

   task automatic wait_prev();
      int n;
      n = 0;
      while (expq.size() != 0 && !bus.res_valid) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            check("wait_prev_result", bus.res_valid, 1);
            break;
         end
      end
   endtask

   task automatic send_word(input logic [7:0] w[$],
                            input int mode,
                            input int addr,
                            input int delay,
                            input bit want_res);
      exp_t       e;
      logic [7:0] st[$];
      bit         ovf;
      int         n;
      wait_prev();
      ovf = 0;
      foreach (w[i]) begin
         if (w[i] != 0) begin
            if (st.size() < CAP) st.push_back(w[i]);
            else ovf = 1;
         end
      end
      e.empty = (st.size() == 0);
      e.found = !e.empty && mode == M_FOUND;
      e.addr  = e.found ? AW'(addr) : '0;
      e.tmo   = !e.empty && mode == M_HANG;
      e.ovf   = ovf;
      e.beats = 8'(w.size());
      cur_chars = st;
      cur_mode  = mode;
      cur_addr  = addr;
      cur_delay = delay;
      if (want_res) expq.push_back(e);
      foreach (w[i]) begin
         if (i > 0 && ($urandom % 4) == 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = w[i];
         bus.in_last  = (i == w.size() - 1);
         n = 0;
         while (!bus.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
               $display("FAIL beat_accept: in_ready stuck 0");
               $fatal(1, "in_ready never returned");
            end
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w[$];
      int n;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      w = '{8'h63, 8'h61, 8'h74};
      send_word(w, M_FOUND, 5, 3, 1);

      w = '{8'h7a, 8'h7a};
      send_word(w, M_MISS, 9, 1, 1);

      w = {};
      for (int i = 0; i < 20; i++)
         w.push_back(8'($urandom_range(1, 255)));
      send_word(w, M_FOUND, 12, 2, 1);

      w = '{8'h00};
      send_word(w, M_FOUND, 3, 1, 1);

      w = '{8'h41, 8'h00, 8'h42};
      send_word(w, M_HANG, 0, 1, 1);

      // reset while the matcher is running
      w = '{8'h71, 8'h72, 8'h73};
      send_word(w, M_HANG, 0, 1, 0);
      n = 0;
      while (!bus.match_cs && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_match", bus.match_cs, 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_drop_match_cs", bus.match_cs, 0);
      check("async_in_ready", bus.in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      stall = 1000;
      w = '{8'h61, 8'h62};
      send_word(w, M_FOUND, 7, 2, 1);
      n = 0;
      while (!bus.res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ab_result", bus.res_valid, 1);
      stall = 5;

      for (int k = 0; k < 25; k++) begin
         w = {};
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++)
            w.push_back((($urandom % 6) == 0) ? 8'h00 :
                        8'($urandom_range(1, 255)));
         send_word(w, $urandom % 3, $urandom % 16,
                   $urandom_range(1, 6), 1);
      end

      n = 0;
      while (expq.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", expq.size(), 0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
